// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs drained round-robin onto a registered common data bus
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package cdb_arbiter_pkg;
    typedef struct packed {
        logic                    valid;
        logic [`ROB_TAG_LEN-1:0] rob_tag;
        logic [`XLEN-1:0]        value;
    } CDB_DATA;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU       = 3,
    parameter int FU_BUF_DEPTH = 2
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [NUM_FU-1:0]                       fu_valid,
    input  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0]     fu_rob_tag,
    input  logic [NUM_FU-1:0][`XLEN-1:0]            fu_value,
    output logic [NUM_FU-1:0]                       fu_ready,
    output CDB_DATA                                 cdb_data
);
    localparam int AW = FU_BUF_DEPTH > 1 ? $clog2(FU_BUF_DEPTH) : 1;
    localparam int CW = $clog2(FU_BUF_DEPTH + 1);
    localparam int IW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;

    logic [`ROB_TAG_LEN-1:0] mem_tag [NUM_FU][FU_BUF_DEPTH];
    logic [`XLEN-1:0]        mem_val [NUM_FU][FU_BUF_DEPTH];
    logic [AW-1:0]           head    [NUM_FU];
    logic [AW-1:0]           tail    [NUM_FU];
    logic [CW-1:0]           count   [NUM_FU];
    logic [IW-1:0]           rr_ptr, gnt, idx;
    logic                    gnt_valid;
    logic [NUM_FU-1:0]       push, pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(FU_BUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at the registered count, so it never waits on this cycle's grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        idx       = '0;
        fu_ready  = '0;
        push      = '0;
        pop       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_FU);
            if (!gnt_valid && count[idx] != '0) begin
                gnt_valid = 1'b1;
                gnt       = idx;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = count[i] < CW'(FU_BUF_DEPTH) && !reset && !flush;
            push[i]     = fu_valid[i] && fu_ready[i];
            pop[i]      = gnt_valid && gnt == IW'(i);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_tag[i][tail[i]] <= fu_rob_tag[i];
                mem_val[i][tail[i]] <= fu_value[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            cdb_data <= '0;
            if (reset) rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) tail[i] <= nxt(tail[i]);
                if (pop[i]) head[i] <= nxt(head[i]);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            cdb_data <= gnt_valid ? {1'b1, mem_tag[gnt][head[gnt]], mem_val[gnt][head[gnt]]} : '0;
            if (gnt_valid) rr_ptr <= gnt == IW'(NUM_FU - 1) ? '0 : gnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench; a cycle model predicts every CDB broadcast and scenario tasks add targeted checks
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;
    localparam int N  = 3;
    localparam int D  = 2;
    localparam int TW = `ROB_TAG_LEN;
    localparam int XW = `XLEN;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   flush = 1'b0;
    logic [N-1:0]           fu_valid = '0;
    logic [N-1:0][TW-1:0]   fu_rob_tag = '0;
    logic [N-1:0][XW-1:0]   fu_value = '0;
    logic [N-1:0]           fu_ready;
    CDB_DATA                cdb_data;

    int n_checks = 0;
    int n_fail = 0;
    CDB_DATA exp_q[$];
    CDB_DATA obs_q[$];
    logic [TW+XW-1:0] mq [N][$];
    int m_rr = 0;
    logic [N-1:0] acc;

    cdb_arbiter #(.NUM_FU(N), .FU_BUF_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .flush(flush), .fu_valid(fu_valid),
        .fu_rob_tag(fu_rob_tag), .fu_value(fu_value), .fu_ready(fu_ready), .cdb_data(cdb_data)
    );

    always #5 clock = ~clock;

    // Predict this edge from the current inputs, then record what the DUT registered.
    task automatic tick();
        CDB_DATA e;
        int sz[N];
        bit found;
        e = '0;
        found = 0;
        acc = '0;
        if (reset || flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            if (reset) m_rr = 0;
        end else begin
            for (int i = 0; i < N; i++) sz[i] = mq[i].size();
            for (int k = 0; k < N; k++) begin
                int j = (m_rr + k) % N;
                if (!found && sz[j] > 0) begin
                    found = 1;
                    e = {1'b1, mq[j].pop_front()};
                    m_rr = (j + 1) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (fu_valid[i] && sz[i] < D) begin
                    acc[i] = 1'b1;
                    mq[i].push_back({fu_rob_tag[i], fu_value[i]});
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        obs_q.push_back(cdb_data);
    endtask

    task automatic test_reset();
        CDB_DATA e, o;
        reset = 1'b1;
        fu_valid = '1;
        fu_rob_tag = {5'd3, 5'd2, 5'd1};
        tick();
        tick();
        n_checks++;
        if (fu_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b expected %b", fu_ready, 3'b000); end
        n_checks++;
        if (cdb_data !== '0) begin n_fail++; $display("FAIL reset_cdb got %h expected 0", cdb_data); end
        reset = 1'b0;
        fu_valid = '0;
        #1;
        n_checks++;
        if (fu_ready !== '1) begin n_fail++; $display("FAIL release_ready got %b expected %b", fu_ready, 3'b111); end
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL sb_reset got %h expected %h", o, e); end
        end
    endtask

    task automatic test_contention();
        CDB_DATA e, o, want;
        logic [TW-1:0] et[3] = '{5'd0, 5'd1, 5'd3};
        logic [XW-1:0] ev[3] = '{32'hA, 32'hB, 32'hC};
        fu_valid = 3'b111;
        for (int i = 0; i < N; i++) begin fu_rob_tag[i] = et[i]; fu_value[i] = ev[i]; end
        tick();
        fu_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            want = i < 3 ? {1'b1, et[i], ev[i]} : '0;
            n_checks++;
            if (cdb_data !== want) begin n_fail++; $display("FAIL contention_%0d got %h expected %h", i, cdb_data, want); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL sb_contention got %h expected %h", o, e); end
        end
    endtask

    task automatic test_fairness();
        CDB_DATA e, o;
        int cnt[N] = '{0, 0, 0};
        int g[$];
        fu_valid = 3'b111;
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < N; i++) begin
                fu_rob_tag[i] = TW'(i * 8 + cnt[i] % 8);
                fu_value[i] = XW'(i * 256 + cnt[i]);
            end
            tick();
            for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
        end
        fu_valid = '0;
        repeat (10) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.valid) g.push_back(int'(o.rob_tag[4:3]));
            if (o !== e) begin n_fail++; $display("FAIL sb_fairness got %h expected %h", o, e); end
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (i >= g.size() || g[i] != i % N) begin
                n_fail++;
                $display("FAIL fairness_grant_%0d got %0d expected %0d", i, i < g.size() ? g[i] : -1, i % N);
            end
        end
        n_checks++;
        if (g.size() != cnt[0] + cnt[1] + cnt[2]) begin
            n_fail++; $display("FAIL fairness_total got %0d expected %0d", g.size(), cnt[0] + cnt[1] + cnt[2]);
        end
    endtask

    task automatic test_single();
        CDB_DATA e, o, want;
        fu_valid = 3'b010;
        fu_rob_tag[1] = 5'd2;
        fu_value[1] = 32'h5;
        tick();
        fu_valid = '0;
        n_checks++;
        if (cdb_data !== '0) begin n_fail++; $display("FAIL single_bypass got %h expected 0", cdb_data); end
        tick();
        want = {1'b1, 5'd2, 32'h5};
        n_checks++;
        if (cdb_data !== want) begin n_fail++; $display("FAIL single_bcast got %h expected %h", cdb_data, want); end
        tick();
        n_checks++;
        if (cdb_data !== '0) begin n_fail++; $display("FAIL single_after got %h expected 0", cdb_data); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL sb_single got %h expected %h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        CDB_DATA e, o;
        logic [XW-1:0] bv[3] = '{32'h11, 32'h22, 32'h33};
        logic [XW-1:0] f0[$];
        bit held = 0;
        int w;
        reset = 1'b1;
        fu_valid = '0;
        tick();
        reset = 1'b0;
        fu_valid = 3'b110;
        fu_rob_tag[1] = 5'd5; fu_value[1] = 32'h100;
        fu_rob_tag[2] = 5'd6; fu_value[2] = 32'h200;
        tick();
        if (acc[1]) fu_value[1] = fu_value[1] + 1;
        if (acc[2]) fu_value[2] = fu_value[2] + 1;
        fu_valid[0] = 1'b1;
        fu_rob_tag[0] = 5'd4;
        for (int k = 0; k < 3; k++) begin
            fu_value[0] = bv[k];
            w = 0;
            do begin
                if (k == 2 && !fu_ready[0]) held = 1;
                tick();
                if (acc[1]) fu_value[1] = fu_value[1] + 1;
                if (acc[2]) fu_value[2] = fu_value[2] + 1;
                w++;
            end while (!acc[0] && w < 20);
            n_checks++;
            if (!acc[0]) begin n_fail++; $display("FAIL bp_accept_%0d got timeout expected accept", k); end
        end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL bp_held got ready expected fu_ready[0]=0 while 0x33 waits"); end
        fu_valid = '0;
        repeat (12) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.valid && o.rob_tag == 5'd4) f0.push_back(o.value);
            if (o !== e) begin n_fail++; $display("FAIL sb_backpressure got %h expected %h", o, e); end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= f0.size() || f0[i] !== bv[i]) begin
                n_fail++; $display("FAIL bp_order_%0d got %h expected %h", i, i < f0.size() ? f0[i] : 'x, bv[i]);
            end
        end
    endtask

    task automatic test_flush();
        CDB_DATA e, o;
        bit stale = 0;
        int nv = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fu_valid = 3'b101; fu_rob_tag[0] = 5'd10; fu_rob_tag[2] = 5'd12;
        fu_value[0] = 32'hA0; fu_value[2] = 32'hC0;
        tick();
        fu_valid = 3'b001; fu_rob_tag[0] = 5'd11; fu_value[0] = 32'hA1;
        tick();
        fu_valid = 3'b101; fu_rob_tag[0] = 5'd14; fu_rob_tag[2] = 5'd13;
        fu_value[0] = 32'hA4; fu_value[2] = 32'hC3;
        tick();
        flush = 1'b1;
        fu_valid = 3'b111; fu_rob_tag = {5'd22, 5'd21, 5'd20};
        #1;
        n_checks++;
        if (fu_ready !== '0) begin n_fail++; $display("FAIL flush_ready got %b expected %b", fu_ready, 3'b000); end
        tick();
        flush = 1'b0;
        fu_valid = '0;
        n_checks++;
        if (cdb_data !== '0) begin n_fail++; $display("FAIL flush_cdb got %h expected 0", cdb_data); end
        #1;
        n_checks++;
        if (fu_ready !== '1) begin n_fail++; $display("FAIL flush_ready_after got %b expected %b", fu_ready, 3'b111); end
        repeat (5) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.valid) nv++;
            if (o.valid && o.rob_tag inside {5'd11, 5'd13, 5'd14, 5'd20, 5'd21, 5'd22}) stale = 1;
            if (o !== e) begin n_fail++; $display("FAIL sb_flush got %h expected %h", o, e); end
        end
        n_checks++;
        if (stale) begin n_fail++; $display("FAIL flush_stale got stale tag expected none"); end
        n_checks++;
        if (nv != 2) begin n_fail++; $display("FAIL flush_count got %0d expected 2", nv); end
    endtask

    task automatic test_reset_mid();
        CDB_DATA e, o, want;
        fu_valid = 3'b011; fu_rob_tag[0] = 5'd15; fu_rob_tag[1] = 5'd16;
        tick();
        fu_valid = 3'b001; fu_rob_tag[0] = 5'd17;
        tick();
        reset = 1'b1;
        fu_valid = 3'b111;
        #1;
        n_checks++;
        if (fu_ready !== '0) begin n_fail++; $display("FAIL rmid_ready got %b expected %b", fu_ready, 3'b000); end
        tick();
        n_checks++;
        if (cdb_data !== '0) begin n_fail++; $display("FAIL rmid_cdb got %h expected 0", cdb_data); end
        tick();
        n_checks++;
        if (fu_ready !== '0 || cdb_data !== '0) begin
            n_fail++; $display("FAIL rmid_hold got ready=%b cdb=%h expected ready=000 cdb=0", fu_ready, cdb_data);
        end
        reset = 1'b0;
        fu_valid = 3'b100; fu_rob_tag[2] = 5'd1; fu_value[2] = 32'h7;
        tick();
        fu_valid = '0;
        n_checks++;
        if (cdb_data !== '0) begin n_fail++; $display("FAIL rmid_no_old got %h expected 0", cdb_data); end
        tick();
        want = {1'b1, 5'd1, 32'h7};
        n_checks++;
        if (cdb_data !== want) begin n_fail++; $display("FAIL rmid_first got %h expected %h", cdb_data, want); end
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL sb_reset_mid got %h expected %h", o, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_contention();
        test_fairness();
        test_single();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_FU, 3, number of functional-unit (FU) result ports.
REQ-002 Parameter: FU_BUF_DEPTH, 2, per-FU result FIFO depth in entries (>=1).
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: flush  input  1  synchronous pipeline flush (mispredict); discards all buffered results.
REQ-006 Port: fu_valid  input  [NUM_FU]  FU i presents a completed result.
REQ-007 Port: fu_rob_tag  input  [NUM_FU][`ROB_TAG_LEN]  ROB tag of FU i result.
REQ-008 Port: fu_value  input  [NUM_FU][`XLEN]  result value of FU i.
REQ-009 Port: fu_ready  output  [NUM_FU]  FIFO i can accept a result this cycle.
REQ-010 Port: cdb_data  output  CDB_DATA {valid, rob_tag, value}  registered CDB broadcast consumed by the ROB and reservation stations.

Function
REQ-011 Each FU i SHALL own an in-order FIFO of FU_BUF_DEPTH entries holding {rob_tag, value}.
REQ-012 fu_ready[i] SHALL be 1 iff FIFO i count < FU_BUF_DEPTH and reset=0 and flush=0; it SHALL NOT depend on a same-cycle pop, so there is no combinational path from arbitration to fu_ready.
REQ-013 A result SHALL be enqueued at a rising edge iff fu_valid[i] && fu_ready[i]; fu_valid while fu_ready=0 SHALL be ignored (the FU holds it).
REQ-014 Arbitration SHALL be round-robin over non-empty FIFOs, starting the search at priority pointer rr_ptr and wrapping NUM_FU-1 -> 0.
REQ-015 On a grant to FIFO g, the head of g SHALL be popped and registered: cdb_data <= {1, tag, value}; rr_ptr <= (g+1) mod NUM_FU.
REQ-016 When all FIFOs are empty, cdb_data SHALL be registered as {0, 0, 0}, and rr_ptr SHALL hold.
REQ-017 At most one result SHALL be broadcast per cycle; cdb_data.valid SHALL be high for exactly one cycle per granted result.
REQ-018 Latency: a result enqueued into an empty FIFO at edge k, and granted, SHALL appear on cdb_data from edge k+1 until edge k+2; the FIFO does not bypass to the CDB.
REQ-019 Push and pop of the same FIFO in one cycle SHALL both take effect, leaving the count unchanged.
REQ-020 Results from one FU SHALL be broadcast in acceptance order; no result may be lost or duplicated.
REQ-021 Pointer wrap: head and tail indices SHALL wrap modulo FU_BUF_DEPTH, and the count SHALL distinguish full from empty.
REQ-022 flush=1 at an edge SHALL empty all FIFOs, register cdb_data <= {0,0,0}, and drop any same-cycle input; rr_ptr SHALL hold.
REQ-023 The value on cdb_data while valid=0 SHALL always be tag 0 and value 0.

Reset
REQ-024 reset=1 at an edge SHALL empty all FIFOs, set rr_ptr=0 and cdb_data={0,0,0}, and discard same-cycle inputs; reset has priority over flush.
REQ-025 fu_ready SHALL be all-0 while reset is asserted, and all-1 in the first cycle after deassertion.
REQ-026 Assertion of reset mid-operation SHALL drop buffered results without broadcasting them.

Verification
REQ-027 Single result: FU1 {tag 2, value 0x5} accepted at edge k -> cdb_data={1,2,0x5} after edge k+1 for one cycle, then {0,0,0}.
REQ-028 Contention: FU0 {tag 0,0xA}, FU1 {tag 1,0xB} and FU2 {tag 3,0xC} accepted at the same edge, rr_ptr=0 -> broadcasts are tag 0, tag 1, tag 3 on consecutive cycles, and rr_ptr ends at 0.
REQ-029 Fairness: all three FUs continuously valid -> grants rotate 0,1,2,0,1,2; no FU waits more than NUM_FU cycles.
REQ-030 Backpressure: FU0 pushes 0x11, 0x22, 0x33 on consecutive cycles while FU1/FU2 are saturated -> fu_ready[0]=0 once 2 entries are held, 0x33 is held by FU0 until ready, and output order is 0x11, 0x22, 0x33.
REQ-031 Flush: 2 entries buffered in FU0 and 1 in FU2, flush pulsed -> next cycle cdb_data.valid=0, all fu_ready=1, and no stale tags ever broadcast.
REQ-032 Reset mid-stream: reset asserted with buffered entries -> cdb_data={0,0,0}, fu_ready=0 during reset, and after release FU2 {tag 1,0x7} is the first broadcast, granted as the only non-empty FIFO.
